// File: rtl/flow_distributor_n.sv
// flow_distributor_n: deals a block stream round-robin across NUM_FLOWS flows and presents
// each complete round as one wide word. Optional round counter: `define FLOW_DIST_ROUND_CNT_EN.
module flow_distributor_n #(
   parameter int BITS_BLOCK    = 257,
   parameter int NUM_FLOWS     = 2,
   parameter int ROUNDS_PER_AM = 4096
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [BITS_BLOCK-1:0]             in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              align,
   output logic [NUM_FLOWS*BITS_BLOCK-1:0]   flows,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              err_partial,
   output logic [$clog2(ROUNDS_PER_AM)-1:0]  round_cnt,
   output logic                              am_round
);
   localparam int IDX_W = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;
   localparam int STG_N = (NUM_FLOWS > 1) ? NUM_FLOWS - 1 : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FLOWS - 1);

   logic [IDX_W-1:0]                idx_q, idx_d, idx_eff;
   logic [STG_N*BITS_BLOCK-1:0]     stage_q, stage_d;
   logic [NUM_FLOWS*BITS_BLOCK-1:0] flows_q, flows_d;
   logic                            out_valid_q, out_valid_d;
   logic                            err_partial_q, err_partial_d;
   logic                            in_fire, out_fire, round_done;

   // Handshakes: a transfer occurs on every rising edge where valid && ready; valid never
   // depends on ready, and a producer holding valid keeps its data stable until it transfers.
   // in_ready drops only when the last slot of a round would overwrite an unconsumed round;
   // a same-cycle out_fire frees the output register, so full rate is kept.
   assign idx_eff    = align ? '0 : idx_q;
   assign in_ready   = !(idx_eff == LAST_IDX && out_valid_q && !out_ready);
   assign in_fire    = in_valid && in_ready;
   assign out_fire   = out_valid_q && out_ready;
   assign round_done = in_fire && (idx_eff == LAST_IDX);

   always_comb begin
      idx_d         = idx_eff;
      stage_d       = stage_q;
      flows_d       = flows_q;
      out_valid_d   = out_valid_q;
      err_partial_d = align && (idx_q != '0);
      if (round_done) begin
         for (int k = 0; k < NUM_FLOWS - 1; k++)
            flows_d[k*BITS_BLOCK +: BITS_BLOCK] = stage_q[k*BITS_BLOCK +: BITS_BLOCK];
         flows_d[(NUM_FLOWS-1)*BITS_BLOCK +: BITS_BLOCK] = in_data;
         out_valid_d = 1'b1;
         idx_d       = '0;
      end else begin
         if (in_fire) begin
            for (int k = 0; k < STG_N; k++)
               if (idx_eff == IDX_W'(k)) stage_d[k*BITS_BLOCK +: BITS_BLOCK] = in_data;
            idx_d = idx_eff + IDX_W'(1);
         end
         if (out_fire) out_valid_d = 1'b0;
      end
   end

   // Staging is pure datapath: stale entries are always overwritten before they are used.
   always_ff @(posedge clk) begin
      stage_q <= stage_d;
      if (rst) begin
         idx_q         <= '0;
         flows_q       <= '0;
         out_valid_q   <= 1'b0;
         err_partial_q <= 1'b0;
      end else begin
         idx_q         <= idx_d;
         flows_q       <= flows_d;
         out_valid_q   <= out_valid_d;
         err_partial_q <= err_partial_d;
      end
   end

   assign flows       = flows_q;
   assign out_valid   = out_valid_q;
   assign err_partial = err_partial_q;

`ifdef FLOW_DIST_ROUND_CNT_EN
   localparam int CNT_W = $clog2(ROUNDS_PER_AM);
   logic [CNT_W-1:0] round_cnt_q, round_cnt_d;
   logic             am_round_q, am_round_d;

   // am_round travels with the round it tags, so it loads together with flows.
   always_comb begin
      round_cnt_d = round_cnt_q;
      am_round_d  = am_round_q;
      if (round_done) begin
         am_round_d  = (round_cnt_q == '0);
         round_cnt_d = (round_cnt_q == CNT_W'(ROUNDS_PER_AM - 1)) ? '0
                                                                  : round_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         round_cnt_q <= '0;
         am_round_q  <= 1'b0;
      end else begin
         round_cnt_q <= round_cnt_d;
         am_round_q  <= am_round_d;
      end
   end

   assign round_cnt = round_cnt_q;
   assign am_round  = am_round_q;
`else
   assign round_cnt = '0;
   assign am_round  = 1'b0;
`endif

endmodule

// File: tb/tb_flow_distributor_n.sv
// Bench for flow_distributor_n: a 4-flow instance (index 0) and a 2-flow instance (index 1),
// checked every cycle against a round-assembly model plus hand-computed literals.
module tb_flow_distributor_n;
   logic        clk;
   logic        rst;
   logic [15:0] din  [2];
   logic        vld  [2];
   logic        rdy  [2];
   logic        aln  [2];
   logic        ov   [2];
   logic        ordy [2];
   logic        err  [2];
   logic [1:0]  cnt  [2];
   logic        am   [2];
   logic [63:0] flows_a;
   logic [31:0] flows_b;

   int n_cmp = 0;
   int n_bad = 0;

   flow_distributor_n #(.BITS_BLOCK(16), .NUM_FLOWS(4), .ROUNDS_PER_AM(4)) dut_a (
      .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
      .align(aln[0]), .flows(flows_a), .out_valid(ov[0]), .out_ready(ordy[0]),
      .err_partial(err[0]), .round_cnt(cnt[0]), .am_round(am[0]));

   flow_distributor_n #(.BITS_BLOCK(16), .NUM_FLOWS(2), .ROUNDS_PER_AM(4)) dut_b (
      .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
      .align(aln[1]), .flows(flows_b), .out_valid(ov[1]), .out_ready(ordy[1]),
      .err_partial(err[1]), .round_cnt(cnt[1]), .am_round(am[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Model state: blocks collected for the round in progress, and the presented round.
   logic [15:0] part   [2][4];
   int          plen   [2];
   logic [63:0] m_flows[2];
   logic        m_ov   [2];
   logic        m_err  [2];
   int          m_cnt  [2];
   logic        m_am   [2];

   // Compare at the falling edge, then advance the model with the inputs the next rising
   // edge will sample (inputs only change just after rising edges).
   initial begin
      int   n;
      logic exp_rdy;
      logic fire;
      for (int m = 0; m < 2; m++) begin
         plen[m] = 0; m_flows[m] = '0; m_ov[m] = 1'b0; m_err[m] = 1'b0;
         m_cnt[m] = 0; m_am[m] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            n = (m == 0) ? 4 : 2;
            exp_rdy = !((((aln[m] ? 0 : plen[m]) == n - 1)) && m_ov[m] && !ordy[m]);
            chk($sformatf("in_ready[%0d]", m), 64'(rdy[m]), 64'(exp_rdy));
            chk($sformatf("out_valid[%0d]", m), 64'(ov[m]), 64'(m_ov[m]));
            chk($sformatf("err_partial[%0d]", m), 64'(err[m]), 64'(m_err[m]));
            chk($sformatf("round_cnt[%0d]", m), 64'(cnt[m]), 64'(m_cnt[m]));
            chk($sformatf("am_round[%0d]", m), 64'(am[m]), 64'(m_am[m]));
            if (m == 0) chk("flows[0]", flows_a, m_flows[0]);
            else        chk("flows[1]", {32'h0, flows_b}, m_flows[1]);
            if (rst) begin
               plen[m] = 0; m_flows[m] = '0; m_ov[m] = 1'b0; m_err[m] = 1'b0;
               m_cnt[m] = 0; m_am[m] = 1'b0;
            end else begin
               m_err[m] = aln[m] && (plen[m] != 0);
               if (aln[m]) plen[m] = 0;
               fire = vld[m] && exp_rdy;
               if (fire) begin
                  part[m][plen[m]] = din[m];
                  plen[m]++;
               end
               if (fire && plen[m] == n) begin
                  m_flows[m] = '0;
                  for (int k = 0; k < n; k++) m_flows[m][k*16 +: 16] = part[m][k];
                  m_ov[m] = 1'b1;
                  plen[m] = 0;
`ifdef FLOW_DIST_ROUND_CNT_EN
                  m_am[m]  = (m_cnt[m] == 0);
                  m_cnt[m] = (m_cnt[m] + 1) % 4;
`endif
               end else if (m_ov[m] && ordy[m]) begin
                  m_ov[m] = 1'b0;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int m, input logic [15:0] d);
      din[m] = d;
      vld[m] = 1'b1;
      step();
   endtask

   task automatic idle(input int m);
      vld[m] = 1'b0;
      din[m] = '0;
   endtask

   initial begin
      rst = 1'b1;
      for (int m = 0; m < 2; m++) begin
         din[m] = '0; vld[m] = 1'b0; aln[m] = 1'b0; ordy[m] = 1'b0;
      end
      repeat (3) step();
      chk("rst out_valid", 64'(ov[0]), 64'd0);
      chk("rst flows", flows_a, 64'd0);
      chk("rst err", 64'(err[0]), 64'd0);
      chk("rst in_ready", 64'(rdy[0]), 64'd1);
      rst = 1'b0;
      step();

      // Full-rate streaming on the 4-flow instance.
      ordy[0] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         put(0, 16'(i));
         if (i == 4) chk("round1 flows", flows_a, 64'h0004_0003_0002_0001);
         if (i == 4) chk("round1 valid", 64'(ov[0]), 64'd1);
         if (i == 5) chk("round1 consumed", 64'(ov[0]), 64'd0);
         if (i == 8) chk("round2 flows", flows_a, 64'h0008_0007_0006_0005);
      end
      idle(0);
      step();

      // Backpressure on the 2-flow instance.
      ordy[1] = 1'b0;
      put(1, 16'h000A);
      put(1, 16'h000B);
      chk("bp flows BA", {32'h0, flows_b}, 64'h000B_000A);
      chk("bp valid", 64'(ov[1]), 64'd1);
      put(1, 16'h000C);
      din[1] = 16'h000D;
      #1;
      chk("bp D stalled", 64'(rdy[1]), 64'd0);
      repeat (3) step();
      chk("bp flows held", {32'h0, flows_b}, 64'h000B_000A);
      ordy[1] = 1'b1;
      #1;
      chk("bp D ready", 64'(rdy[1]), 64'd1);
      step();
      chk("bp flows DC", {32'h0, flows_b}, 64'h000D_000C);
      idle(1);
      step();
      chk("bp drained", 64'(ov[1]), 64'd0);

      // Align after two blocks while an earlier round is still unconsumed.
      ordy[0] = 1'b0;
      for (int i = 0; i < 4; i++) put(0, 16'h0011 + 16'(i));
      put(0, 16'h0021);
      put(0, 16'h0022);
      idle(0);
      aln[0] = 1'b1;
      step();
      chk("align err pulse", 64'(err[0]), 64'd1);
      aln[0] = 1'b0;
      step();
      chk("align err clear", 64'(err[0]), 64'd0);
      chk("align old round kept", flows_a, 64'h0014_0013_0012_0011);
      chk("align old valid", 64'(ov[0]), 64'd1);
      put(0, 16'h0031);
      put(0, 16'h0032);
      put(0, 16'h0033);
      ordy[0] = 1'b1;
      put(0, 16'h0034);
      chk("align new round", flows_a, 64'h0034_0033_0032_0031);

      // Align together with an accepted block at the last slot.
      put(0, 16'h0041);
      put(0, 16'h0042);
      put(0, 16'h0043);
      aln[0] = 1'b1;
      put(0, 16'h0045);
      aln[0] = 1'b0;
      chk("align+fire err", 64'(err[0]), 64'd1);
      chk("align+fire no round", 64'(ov[0]), 64'd0);
      put(0, 16'h0046);
      put(0, 16'h0047);
      put(0, 16'h0048);
      chk("align+fire flows", flows_a, 64'h0048_0047_0046_0045);
      idle(0);
      step();

      // Reset mid-round with a round presented.
      ordy[0] = 1'b0;
      for (int i = 0; i < 6; i++) put(0, 16'h0051 + 16'(i));
      idle(0);
      rst = 1'b1;
      step();
      chk("midrst out_valid", 64'(ov[0]), 64'd0);
      chk("midrst err", 64'(err[0]), 64'd0);
      chk("midrst in_ready", 64'(rdy[0]), 64'd1);
      chk("midrst flows", flows_a, 64'd0);
      rst = 1'b0;
      ordy[0] = 1'b1;
      for (int i = 0; i < 4; i++) put(0, 16'h0061 + 16'(i));
      chk("postrst flows", flows_a, 64'h0064_0063_0062_0061);
      idle(0);

      // Nine rounds on the 2-flow instance for the round counter.
      ordy[1] = 1'b1;
      for (int r = 1; r <= 9; r++) begin
         put(1, 16'(2 * r - 1));
         put(1, 16'(2 * r));
`ifdef FLOW_DIST_ROUND_CNT_EN
         chk($sformatf("am_round r%0d", r), 64'(am[1]), 64'(((r - 1) % 4) == 0));
         chk($sformatf("round_cnt r%0d", r), 64'(cnt[1]), 64'(r % 4));
`else
         chk($sformatf("am_round r%0d", r), 64'(am[1]), 64'd0);
         chk($sformatf("round_cnt r%0d", r), 64'(cnt[1]), 64'd0);
`endif
      end
      idle(1);
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/flow_distributor_n.md
# flow_distributor_n

Parametrised N-way round-robin flow distributor for the AUI transmit path. Accepts a stream of BITS_BLOCK-bit blocks under valid/ready and deals consecutive blocks to NUM_FLOWS flows. It presents a complete round (one block per flow) as a single wide output word under valid/ready. It sits between the block encoder/AM mapper and the per-flow lane logic. It adds backpressure, an arbitrary flow count and a realignment input that restarts dealing at flow 0.

## Interface
- BITS_BLOCK, 257, width of one block.
- NUM_FLOWS, 2, number of flows (1..16).
- ROUNDS_PER_AM, 4096, round-counter modulus; used only with FLOW_DIST_ROUND_CNT_EN.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  BITS_BLOCK  input block.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepted when in_valid && in_ready (combinational).
- align  in  1  restart dealing at flow 0; discard partial round.
- flows  out  NUM_FLOWS*BITS_BLOCK  flow k at [k*BITS_BLOCK +: BITS_BLOCK].
- out_valid  out  1  flows holds a complete round.
- out_ready  in  1  round consumed when out_valid && out_ready.
- err_partial  out  1  one-cycle pulse: partial round discarded by align.
- round_cnt  out  $clog2(ROUNDS_PER_AM)  rounds emitted mod ROUNDS_PER_AM (macro only).
- am_round  out  1  high while the presented round has round_cnt==0 (macro only).

## Operation
- State: flow index idx (0..NUM_FLOWS-1), staging registers for flows 0..NUM_FLOWS-2, output register flows, out_valid.
- in_fire = in_valid && in_ready. out_fire = out_valid && out_ready.
- On in_fire with idx < NUM_FLOWS-1: store the block in staging[idx], then idx++.
- On in_fire with idx == NUM_FLOWS-1 (round complete):
  - flows <= {in_data, staging[NUM_FLOWS-2..0]}.
  - out_valid <= 1.
  - idx <= 0.
- in_ready = !(idx == NUM_FLOWS-1 && out_valid && !out_ready). The block stalls only on the last slot while the previous round is still unconsumed. A same-cycle out_fire frees the output register, so the pipeline runs at full rate.
- out_fire without round completion: out_valid <= 0. flows holds its value.
- align:
  - Sampled every cycle, independent of in_valid.
  - idx is forced to 0 before the in_fire rule is applied. An in_fire block in the same cycle goes to flow 0, so idx becomes 1 (or a round completes if NUM_FLOWS==1).
  - err_partial <= 1 for one cycle if idx != 0 when align is sampled; otherwise 0.
  - Staged blocks are not cleared; they are overwritten.
  - The output register and out_valid are unaffected.
- NUM_FLOWS==1: no staging; every accepted block completes a round.

## Timing
- Reset values:
  - idx = 0, out_valid = 0, flows = 0, err_partial = 0.
  - round_cnt = 0, am_round = 0.
  - in_ready = 1 after reset.
- Latency: last block of a round accepted in cycle t; flows/out_valid valid from cycle t+1.
- Throughput: one block per cycle sustained while out_ready is held high.
- flows and out_valid are stable while out_valid && !out_ready.
- Reset mid-round: the partial round is lost silently; no err_partial.

## Configuration
- FLOW_DIST_ROUND_CNT_EN defined:
  - round_cnt increments on each round completion and wraps ROUNDS_PER_AM-1 -> 0.
  - am_round is registered with flows: it is 1 when the round being loaded has round_cnt==0 before the increment.
  - align does not affect round_cnt.
- FLOW_DIST_ROUND_CNT_EN undefined: round_cnt and am_round are tied to 0 and no counter logic is synthesised.

## Test plan
- NUM_FLOWS=4, blocks 1..8 with in_valid high and out_ready high:
  - out_valid one cycle after blocks 4 and 8.
  - flows = {4,3,2,1} then {8,7,6,5}.
  - in_ready always 1.
- NUM_FLOWS=2, out_ready low, blocks A,B,C,D offered:
  - flows = {B,A} held.
  - C accepted, in_ready=0 while D waits.
  - Raise out_ready: D is accepted the same cycle and flows = {D,C} next cycle.
- NUM_FLOWS=4, align after 2 blocks:
  - err_partial pulses once.
  - The next 4 blocks W,X,Y,Z give flows = {Z,Y,X,W}.
  - A round presented before the align stays valid until consumed.
- align with in_fire of block E at idx=3:
  - E lands in flow 0 and idx = 1.
  - err_partial = 1; no round emitted.
- Reset asserted with idx=2 and out_valid=1: next cycle out_valid=0, idx=0, err_partial=0, in_ready=1.
- Macro defined, ROUNDS_PER_AM=4, 9 rounds:
  - am_round high on rounds 1, 5 and 9.
  - round_cnt sequence 1,2,3,0,1,…; undefined build shows round_cnt=0 and am_round=0 throughout.
